// File: rtl/counter_updown_mod_pkg.sv
// Shared constants for the up/down modulo counter: standard moduli and
// direction encodings used by the counter and by anything that drives it.
package counter_updown_mod_pkg;

  localparam int MOD_BINARY4 = 16;
  localparam int MOD_DECADE  = 10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_updown_mod.sv
// Synchronous up/down modulo counter with parallel load (clamped to the count
// range), count enable, combinational terminal count and a registered wrap pulse.
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = MOD_BINARY4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] y_next;
  logic             wrap_next;

  assign at_max   = (y == MAX_VAL);
  assign at_zero  = (y == '0);
  assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

  // Both wrap points are explicit, so MODULO = 2**WIDTH never relies on overflow.
  always_comb begin
    y_next    = y;
    wrap_next = 1'b0;
    if (load) begin
      y_next = load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (at_max) begin
          y_next    = '0;
          wrap_next = 1'b1;
        end else begin
          y_next = y + ONE;
        end
      end else begin
        if (at_zero) begin
          y_next    = MAX_VAL;
          wrap_next = 1'b1;
        end else begin
          y_next = y - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y    <= '0;
      wrap <= 1'b0;
    end else begin
      y    <= y_next;
      wrap <= wrap_next;
    end
  end

  // Unregistered so a chained stage advances on the same edge this one wraps.
  assign tc = en & ((up & at_max) | (~up & at_zero));

endmodule
